mul_hilo_ctrl: RTL and testbench

Sequencing and result-capture stage wrapped around the combinational 32x32 signed Booth multiplier in the ALU.
- Latches operands on a start request and drives them into the multiplier.
- Waits a fixed settling latency, then captures the 64-bit product into architectural HI/LO registers.
- Provides busy/done handshake to the control unit and direct HI/LO writes for move-to-HI/LO instructions.

---
 rtl/mul_hilo_ctrl_if.sv | 30 +++
 rtl/mul_hilo_ctrl.sv | 87 ++++++++
 tb/tb_mul_hilo_ctrl.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_hilo_ctrl_if.sv
// Bus bundle for mul_hilo_ctrl: control-unit handshake, multiplier operand/product path
// and the architectural HI/LO register interface.
interface mul_hilo_ctrl_if;
    // start is sampled on a rising edge only when the block is idle or completing;
    // busy is high from the accepting edge until the capture edge; done is a
    // one-cycle pulse after the capture edge. A start seen while busy is dropped.
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [63:0] mul_p;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, a, b, mul_p, hi_we, lo_we, wdata,
        input  busy, done, mul_a, mul_b, hi, lo
    );

    modport slave (
        input  start, a, b, mul_p, hi_we, lo_we, wdata,
        output busy, done, mul_a, mul_b, hi, lo
    );
endinterface

// File: rtl/mul_hilo_ctrl.sv
// Sequencer around the combinational 32x32 multiplier: latches operands, waits LATENCY cycles,
// captures the product into HI/LO. Optional macro UNSIGNED_MUL_EN adds unsigned-product correction.
module mul_hilo_ctrl #(
    parameter int LATENCY = 2,
    parameter int CNT_W   = 4
) (
    input  logic              clock,
    input  logic              clear,
`ifdef UNSIGNED_MUL_EN
    input  logic              mul_unsigned,
`endif
    mul_hilo_ctrl_if.slave    bus,
    output logic              dbg_state
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic [63:0]        capture;
    logic               last;

    assign last      = (state == RUN) && (count == '0);
    assign dbg_state = (state == RUN);

`ifdef UNSIGNED_MUL_EN
    logic uns_q;

    // Turning a signed product into the unsigned one adds back each operand shifted by 32
    // wherever the other operand's sign bit was set.
    always_comb begin
        capture = bus.mul_p;
        if (uns_q && bus.mul_a[31]) capture = capture + {bus.mul_b, 32'h0};
        if (uns_q && bus.mul_b[31]) capture = capture + {bus.mul_a, 32'h0};
    end
`else
    assign capture = bus.mul_p;
`endif

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state     <= IDLE;
            count     <= '0;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
            bus.mul_a <= '0;
            bus.mul_b <= '0;
            bus.hi    <= '0;
            bus.lo    <= '0;
`ifdef UNSIGNED_MUL_EN
            uns_q     <= 1'b0;
`endif
        end else begin
            bus.done <= 1'b0;

            if (state == IDLE) begin
                if (bus.hi_we) bus.hi <= bus.wdata;
                if (bus.lo_we) bus.lo <= bus.wdata;
            end

            if (last) begin
                {bus.hi, bus.lo} <= capture;
                bus.done         <= 1'b1;
                bus.busy         <= 1'b0;
                state            <= IDLE;
            end else if (state == RUN) begin
                count <= count - 1'b1;
            end

            // The completing edge also accepts a new start so products stream every LATENCY cycles.
            if ((state == IDLE || last) && bus.start) begin
                bus.mul_a <= bus.a;
                bus.mul_b <= bus.b;
                count     <= CNT_W'(LATENCY - 1);
                bus.busy  <= 1'b1;
                state     <= RUN;
`ifdef UNSIGNED_MUL_EN
                uns_q     <= mul_unsigned;
`endif
            end
        end
    end

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// Self-checking bench for mul_hilo_ctrl: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a completion-time reference model.
module tb_mul_hilo_ctrl;

    localparam int LATENCY = 2;

    logic clock;
    logic clear;
    logic dbg_state;
`ifdef UNSIGNED_MUL_EN
    logic mul_unsigned;
`endif

    mul_hilo_ctrl_if bus ();

    mul_hilo_ctrl #(
        .LATENCY (LATENCY),
        .CNT_W   (4)
    ) dut (
        .clock        (clock),
        .clear        (clear),
`ifdef UNSIGNED_MUL_EN
        .mul_unsigned (mul_unsigned),
`endif
        .bus          (bus.slave),
        .dbg_state    (dbg_state)
    );

    // Stand-in for the ALU's combinational signed multiplier.
    assign bus.mul_p = $signed({{32{bus.mul_a[31]}}, bus.mul_a}) *
                       $signed({{32{bus.mul_b[31]}}, bus.mul_b});

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks the edge at which the in-flight product must land.
    int          cyc;
    int          m_finish;
    logic        m_inflight;
    logic        m_done;
    logic        was_idle;
    logic [63:0] m_prod;
    logic [31:0] m_hi, m_lo, m_mul_a, m_mul_b;

    function automatic logic [63:0] product(input logic [31:0] x, input logic [31:0] y,
                                            input logic uns);
        longint sx, sy;
        if (uns) return {32'h0, x} * {32'h0, y};
        sx = longint'(int'(x));
        sy = longint'(int'(y));
        return 64'(sx * sy);
    endfunction

    always @(posedge clock or negedge clear) begin
        if (!clear) begin
            cyc = 0; m_finish = 0; m_inflight = 0; m_done = 0; m_prod = '0;
            m_hi = '0; m_lo = '0; m_mul_a = '0; m_mul_b = '0;
        end else begin
            cyc++;
            m_done   = 1'b0;
            was_idle = !m_inflight;
            if (m_inflight && cyc == m_finish) begin
                {m_hi, m_lo} = m_prod;
                m_done       = 1'b1;
                m_inflight   = 1'b0;
            end
            if (was_idle) begin
                if (bus.hi_we) m_hi = bus.wdata;
                if (bus.lo_we) m_lo = bus.wdata;
            end
            if (!m_inflight && bus.start) begin
                m_inflight = 1'b1;
                m_finish   = cyc + LATENCY;
                m_mul_a    = bus.a;
                m_mul_b    = bus.b;
`ifdef UNSIGNED_MUL_EN
                m_prod     = product(bus.a, bus.b, mul_unsigned);
`else
                m_prod     = product(bus.a, bus.b, 1'b0);
`endif
            end
        end
    end

    always @(negedge clock) begin
        if (clear) begin
            check("busy",  64'(bus.busy),  64'(m_inflight));
            check("done",  64'(bus.done),  64'(m_done));
            check("hi",    64'(bus.hi),    64'(m_hi));
            check("lo",    64'(bus.lo),    64'(m_lo));
            check("mul_a", 64'(bus.mul_a), 64'(m_mul_a));
            check("mul_b", 64'(bus.mul_b), 64'(m_mul_b));
            check("state", 64'(dbg_state), 64'(m_inflight));
        end
    end

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        clear = 1'b0;
        bus.start = 1'b0; bus.a = '0; bus.b = '0;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
`ifdef UNSIGNED_MUL_EN
        mul_unsigned = 1'b0;
`endif
        repeat (2) @(negedge clock);
        check("rst_busy",  64'(bus.busy),  64'h0);
        check("rst_done",  64'(bus.done),  64'h0);
        check("rst_hi",    64'(bus.hi),    64'h0);
        check("rst_lo",    64'(bus.lo),    64'h0);
        check("rst_mul_a", 64'(bus.mul_a), 64'h0);
        clear = 1'b1;

        // Signed product 7 * -3.
        @(negedge clock); bus.start = 1'b1; bus.a = 32'd7; bus.b = 32'hFFFF_FFFD;
        @(negedge clock); bus.start = 1'b0;
        check("t1_busy_e0", 64'(bus.busy), 64'h1);
        @(negedge clock);
        check("t1_busy_e1", 64'(bus.busy), 64'h1);
        check("t1_done_e1", 64'(bus.done), 64'h0);
        @(negedge clock);
        check("t1_hi",   64'(bus.hi),   64'hFFFF_FFFF);
        check("t1_lo",   64'(bus.lo),   64'hFFFF_FFEB);
        check("t1_done", 64'(bus.done), 64'h1);
        check("t1_busy", 64'(bus.busy), 64'h0);
        @(negedge clock);
        check("t1_done_fall", 64'(bus.done), 64'h0);

        // Start while busy is dropped.
        @(negedge clock); bus.start = 1'b1; bus.a = 32'd5; bus.b = 32'd6;
        @(negedge clock); bus.a = 32'd9; bus.b = 32'd9;
        @(negedge clock); bus.start = 1'b0;
        @(negedge clock);
        check("t2_hi",    64'(bus.hi),    64'h0);
        check("t2_lo",    64'(bus.lo),    64'h1E);
        check("t2_mul_a", 64'(bus.mul_a), 64'h5);
        @(negedge clock);

        // Asynchronous clear mid-operation abandons the product.
        @(negedge clock); bus.start = 1'b1; bus.a = 32'd3; bus.b = 32'd3;
        @(negedge clock); bus.start = 1'b0;
        @(negedge clock);
        #1 clear = 1'b0;
        #1;
        check("t3_hi",   64'(bus.hi),   64'h0);
        check("t3_lo",   64'(bus.lo),   64'h0);
        check("t3_busy", 64'(bus.busy), 64'h0);
        check("t3_done", 64'(bus.done), 64'h0);
        @(negedge clock); clear = 1'b1;
        repeat (3) @(negedge clock);
        check("t3_lo_after", 64'(bus.lo),   64'h0);
        check("t3_done_after", 64'(bus.done), 64'h0);

        // Direct writes honoured in IDLE, ignored in RUN.
        @(negedge clock); bus.hi_we = 1'b1; bus.wdata = 32'h1234_5678;
        @(negedge clock); bus.hi_we = 1'b0; bus.lo_we = 1'b1; bus.wdata = 32'h9ABC_DEF0;
        @(negedge clock); bus.lo_we = 1'b0;
        check("t4_hi", 64'(bus.hi), 64'h1234_5678);
        check("t4_lo", 64'(bus.lo), 64'h9ABC_DEF0);
        bus.start = 1'b1; bus.a = 32'd1; bus.b = 32'd1;
        @(negedge clock); bus.start = 1'b0; bus.hi_we = 1'b1; bus.lo_we = 1'b1;
        bus.wdata = 32'hDEAD_BEEF;
        @(negedge clock); bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        check("t4_run_hi", 64'(bus.hi), 64'h1234_5678);
        check("t4_run_lo", 64'(bus.lo), 64'h9ABC_DEF0);
        @(negedge clock);
        check("t4_cap_hi", 64'(bus.hi), 64'h0);
        check("t4_cap_lo", 64'(bus.lo), 64'h1);

        // Back-to-back products with start held high.
        @(negedge clock); bus.start = 1'b1; bus.a = 32'd2; bus.b = 32'd3;
        @(negedge clock); bus.a = 32'd4; bus.b = 32'd4;
        @(negedge clock);
        @(negedge clock); bus.start = 1'b0;
        check("t5_done1", 64'(bus.done), 64'h1);
        check("t5_lo1",   64'(bus.lo),   64'h6);
        check("t5_busy1", 64'(bus.busy), 64'h1);
        @(negedge clock);
        check("t5_gap",   64'(bus.done), 64'h0);
        @(negedge clock);
        check("t5_done2", 64'(bus.done), 64'h1);
        check("t5_lo2",   64'(bus.lo),   64'h10);
        @(negedge clock);

`ifdef UNSIGNED_MUL_EN
        @(negedge clock); bus.start = 1'b1; bus.a = 32'hFFFF_FFFF; bus.b = 32'd2; mul_unsigned = 1'b1;
        @(negedge clock); bus.start = 1'b0; mul_unsigned = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("t6_uns_hi", 64'(bus.hi), 64'h1);
        check("t6_uns_lo", 64'(bus.lo), 64'hFFFF_FFFE);
        bus.start = 1'b1; mul_unsigned = 1'b0;
        @(negedge clock); bus.start = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("t6_sgn_hi", 64'(bus.hi), 64'hFFFF_FFFF);
        check("t6_sgn_lo", 64'(bus.lo), 64'hFFFF_FFFE);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            @(negedge clock);
            bus.start = ($urandom_range(0, 2) == 0);
            bus.a     = pick();
            bus.b     = pick();
            bus.hi_we = ($urandom_range(0, 5) == 0);
            bus.lo_we = ($urandom_range(0, 5) == 0);
            bus.wdata = $urandom;
`ifdef UNSIGNED_MUL_EN
            mul_unsigned = $urandom_range(0, 1) == 1;
`endif
            if ($urandom_range(0, 99) == 0) begin
                #1 clear = 1'b0;
                #2 clear = 1'b1;
            end
        end
        @(negedge clock);
        bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        repeat (LATENCY + 2) @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
